// File: rtl/kf8253_bus_initiator.sv
// Host-side KF8253 bus initiator: one command at a time, expanded into SETUP/STROBE/HOLD/GAP bus cycles with a one-cycle response pulse.
// Optional macro KF8253_INITIATOR_ILLEGAL_CHECK_EN rejects count ops with rw_mode 00 or counter 3 (error response, no bus activity).
module kf8253_bus_initiator #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_addr,
  input  logic [1:0]  req_rw_mode,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        chip_select_n,
  output logic        read_enable_n,
  output logic        write_enable_n,
  output logic [1:0]  address,
  output logic [7:0]  data_bus_out,
  output logic        data_bus_oe,
  input  logic [7:0]  data_bus_in
);

  localparam logic [1:0] OP_WRITE_BYTE = 2'b00;
  localparam logic [1:0] OP_READ_BYTE  = 2'b01;
  localparam logic [1:0] OP_LOAD_COUNT = 2'b10;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdat;
    logic       msb;
    logic       last;
  } step_t;

  // Describes bus cycle number idx of a command; mode is already normalised (never 00).
  function automatic step_t step_of(input logic [1:0]  op,
                                    input logic [1:0]  addr,
                                    input logic [1:0]  mode,
                                    input logic [15:0] data,
                                    input logic [1:0]  idx);
    step_t s;
    s      = '0;
    s.addr = addr;
    case (op)
      OP_WRITE_BYTE: begin
        s.wr   = 1'b1;
        s.wdat = data[7:0];
        s.last = 1'b1;
      end
      OP_READ_BYTE: begin
        s.last = 1'b1;
      end
      OP_LOAD_COUNT: begin
        s.wr = 1'b1;
        if ((mode == 2'b10) || ((mode == 2'b11) && (idx != 2'd0))) begin
          s.wdat = data[15:8];
        end else begin
          s.wdat = data[7:0];
        end
        s.last = (mode != 2'b11) || (idx != 2'd0);
      end
      default: begin
        // READ_COUNT: counter-latch command to the control word first, then the reads.
        if (idx == 2'd0) begin
          s.wr   = 1'b1;
          s.addr = 2'd3;
          s.wdat = {addr, 6'b000000};
        end else begin
          s.msb  = (mode == 2'b10) || ((mode == 2'b11) && (idx == 2'd2));
          s.last = (mode != 2'b11) || (idx == 2'd2);
        end
      end
    endcase
    return s;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  cap_addr_q, cap_addr_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] data_q, data_d;
  logic [15:0] acc_q, acc_d;
  logic        cur_wr_q, cur_wr_d;
  logic        cur_msb_q, cur_msb_d;
  logic        cur_last_q, cur_last_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic [1:0]  bus_addr_q, bus_addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
`ifdef KF8253_INITIATOR_ILLEGAL_CHECK_EN
  logic        rsp_error_q, rsp_error_d;
`endif

  logic        illegal;
  logic        enter_setup;
  logic        bus_active;
  logic [1:0]  req_mode_norm;
  step_t       load_step;
  step_t       next_step;

  assign req_mode_norm = (req_rw_mode == 2'b00) ? 2'b11 : req_rw_mode;

`ifdef KF8253_INITIATOR_ILLEGAL_CHECK_EN
  assign illegal = req_op[1] && ((req_rw_mode == 2'b00) || (req_addr == 2'd3));
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    op_d        = op_q;
    cap_addr_d  = cap_addr_q;
    mode_d      = mode_q;
    data_d      = data_q;
    acc_d       = acc_q;
    cur_wr_d    = cur_wr_q;
    cur_msb_d   = cur_msb_q;
    cur_last_d  = cur_last_q;
    bus_addr_d  = bus_addr_q;
    dout_d      = dout_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
`ifdef KF8253_INITIATOR_ILLEGAL_CHECK_EN
    rsp_error_d = 1'b0;
`endif
    load_step   = '0;
    enter_setup = 1'b0;
    next_step   = step_of(op_q, cap_addr_q, mode_q, data_q, idx_q + 2'd1);

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
`ifdef KF8253_INITIATOR_ILLEGAL_CHECK_EN
            rsp_error_d = 1'b1;
`endif
          end else begin
            op_d        = req_op;
            cap_addr_d  = req_addr;
            mode_d      = req_mode_norm;
            data_d      = req_data;
            idx_d       = 2'd0;
            acc_d       = '0;
            load_step   = step_of(req_op, req_addr, req_mode_norm, req_data, 2'd0);
            enter_setup = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          if (!cur_wr_q) begin
            if (cur_msb_q) begin
              acc_d[15:8] = data_bus_in;
            end else begin
              acc_d[7:0] = data_bus_in;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (cur_last_q) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = acc_q;
          end else begin
            idx_d       = idx_q + 2'd1;
            load_step   = next_step;
            enter_setup = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_setup) begin
      state_d    = ST_SETUP;
      cnt_d      = '0;
      bus_addr_d = load_step.addr;
      if (load_step.wr) begin
        dout_d = load_step.wdat;
      end
      cur_wr_d   = load_step.wr;
      cur_msb_d  = load_step.msb;
      cur_last_d = load_step.last;
    end

    // Bus pins are registered from the next state so they never glitch.
    bus_active = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    cs_n_d     = !bus_active;
    wr_n_d     = !((state_d == ST_STROBE) && cur_wr_d);
    rd_n_d     = !((state_d == ST_STROBE) && !cur_wr_d);
    oe_d       = bus_active && cur_wr_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      op_q        <= '0;
      cap_addr_q  <= '0;
      mode_q      <= '0;
      data_q      <= '0;
      acc_q       <= '0;
      cur_wr_q    <= 1'b0;
      cur_msb_q   <= 1'b0;
      cur_last_q  <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      bus_addr_q  <= '0;
      dout_q      <= '0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef KF8253_INITIATOR_ILLEGAL_CHECK_EN
      rsp_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      cap_addr_q  <= cap_addr_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      acc_q       <= acc_d;
      cur_wr_q    <= cur_wr_d;
      cur_msb_q   <= cur_msb_d;
      cur_last_q  <= cur_last_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      bus_addr_q  <= bus_addr_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef KF8253_INITIATOR_ILLEGAL_CHECK_EN
      rsp_error_q <= rsp_error_d;
`endif
    end
  end

  assign req_ready      = (state_q == ST_IDLE) && reset_n;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
`ifdef KF8253_INITIATOR_ILLEGAL_CHECK_EN
  assign rsp_error      = rsp_error_q;
`else
  assign rsp_error      = 1'b0;
`endif
  assign chip_select_n  = cs_n_q;
  assign read_enable_n  = rd_n_q;
  assign write_enable_n = wr_n_q;
  assign address        = bus_addr_q;
  assign data_bus_out   = dout_q;
  assign data_bus_oe    = oe_q;

endmodule

// File: tb/tb_kf8253_bus_initiator.sv
// Self-checking bench for kf8253_bus_initiator: random commands against a queue-based bus-cycle model and a simple PIT read model.
module tb_kf8253_bus_initiator;
  localparam int S = 1;
  localparam int T = 2;
  localparam int G = 1;
  localparam int L = S + T + 1 + G;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_addr;
  logic [1:0]  req_rw_mode;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_error;
  logic        chip_select_n;
  logic        read_enable_n;
  logic        write_enable_n;
  logic [1:0]  address;
  logic [7:0]  data_bus_out;
  logic        data_bus_oe;
  logic [7:0]  data_bus_in;

  always #5 clock = ~clock;

  kf8253_bus_initiator #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_rw_mode(req_rw_mode), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .chip_select_n(chip_select_n), .read_enable_n(read_enable_n), .write_enable_n(write_enable_n),
    .address(address), .data_bus_out(data_bus_out), .data_bus_oe(data_bus_oe),
    .data_bus_in(data_bus_in)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected bus cycles for the command in flight; for reads exp_dat is the byte the PIT returns.
  logic        exp_wr[$];
  logic [1:0]  exp_addr[$];
  logic [7:0]  exp_dat[$];
  logic [7:0]  force_q[$];
  logic [15:0] exp_rsp;
  logic        exp_err;

  function automatic logic [7:0] pit_byte();
    if (force_q.size() > 0) return force_q.pop_front();
    return 8'($urandom);
  endfunction

  function automatic void push_cyc(input logic wr, input logic [1:0] a, input logic [7:0] d);
    exp_wr.push_back(wr);
    exp_addr.push_back(a);
    exp_dat.push_back(d);
  endfunction

  task automatic build_expect(input logic [1:0] op, input logic [1:0] addr,
                              input logic [1:0] mode, input logic [15:0] data);
    logic [1:0] nm;
    logic [7:0] b;
    logic       rejected;
    exp_wr.delete();
    exp_addr.delete();
    exp_dat.delete();
    exp_rsp  = 16'h0000;
    exp_err  = 1'b0;
    rejected = 1'b0;
    nm = (mode == 2'b00) ? 2'b11 : mode;
`ifdef KF8253_INITIATOR_ILLEGAL_CHECK_EN
    if (op[1] && ((mode == 2'b00) || (addr == 2'd3))) begin
      rejected = 1'b1;
      exp_err  = 1'b1;
    end
`endif
    if (!rejected) begin
      case (op)
        2'b00: push_cyc(1'b1, addr, data[7:0]);
        2'b01: begin
          b = pit_byte();
          push_cyc(1'b0, addr, b);
          exp_rsp = {8'h00, b};
        end
        2'b10: begin
          if (nm[0]) push_cyc(1'b1, addr, data[7:0]);
          if (nm[1]) push_cyc(1'b1, addr, data[15:8]);
        end
        default: begin
          push_cyc(1'b1, 2'd3, {addr, 6'b000000});
          if (nm[0]) begin
            b = pit_byte();
            push_cyc(1'b0, addr, b);
            exp_rsp[7:0] = b;
          end
          if (nm[1]) begin
            b = pit_byte();
            push_cyc(1'b0, addr, b);
            exp_rsp[15:8] = b;
          end
        end
      endcase
    end
  endtask

  // Issues one command from a negedge, watches every bus clock until rsp_valid and leaves the bench on that negedge.
  // With b2b clear it also checks the cycle after the response.
  task automatic exec_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [1:0] mode,
                          input logic [15:0] data, input bit b2b);
    int  k, run, gap, ncyc, cur, exp_n, exp_k, limit;
    bit  done, s_exp;
    build_expect(op, addr, mode, data);
    exp_n = exp_wr.size();
    exp_k = (exp_n == 0) ? 1 : exp_n * L + 1;
    limit = exp_k + 20;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_before_issue op=%0d got=%b exp=1", op, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_rw_mode = mode; req_data = data;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = 2'($urandom); req_rw_mode = 2'($urandom); req_data = 16'($urandom);
    k = 0; run = 0; gap = 0; ncyc = 0; cur = 0; done = 1'b0;
    while (!done && k < limit) begin
      @(negedge clock);
      k++;
      data_bus_in = 8'($urandom);
      n_checks++;
      if (!read_enable_n && !write_enable_n) begin
        n_fail++;
        $display("FAIL both_strobes op=%0d k=%0d", op, k);
      end
      if (chip_select_n === 1'b0) begin
        if (run == 0) begin
          if (ncyc > 0) begin
            n_checks++;
            if (gap != G) begin
              n_fail++;
              $display("FAIL gap_len op=%0d cyc=%0d got=%0d exp=%0d", op, ncyc, gap, G);
            end
          end
          cur = ncyc;
          ncyc++;
        end
        run++;
        gap = 0;
        s_exp = (run > S) && (run <= S + T);
        n_checks++;
        if (cur >= exp_n) begin
          n_fail++;
          $display("FAIL extra_bus_cycle op=%0d got=%0d exp=%0d", op, cur + 1, exp_n);
        end else begin
          if ({write_enable_n, read_enable_n} !== {!(exp_wr[cur] && s_exp), !(!exp_wr[cur] && s_exp)}) begin
            n_fail++;
            $display("FAIL strobe op=%0d cyc=%0d pos=%0d got_wr_n=%b got_rd_n=%b exp_write=%b exp_low=%b",
                     op, cur, run, write_enable_n, read_enable_n, exp_wr[cur], s_exp);
          end
          n_checks++;
          if (address !== exp_addr[cur]) begin
            n_fail++;
            $display("FAIL address op=%0d cyc=%0d got=%0d exp=%0d", op, cur, address, exp_addr[cur]);
          end
          n_checks++;
          if (exp_wr[cur] && (data_bus_out !== exp_dat[cur] || data_bus_oe !== 1'b1)) begin
            n_fail++;
            $display("FAIL write_data op=%0d cyc=%0d got=%h oe=%b exp=%h oe=1", op, cur, data_bus_out, data_bus_oe, exp_dat[cur]);
          end else if (!exp_wr[cur] && data_bus_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL read_oe op=%0d cyc=%0d got=%b exp=0", op, cur, data_bus_oe);
          end
          if (!exp_wr[cur] && s_exp) data_bus_in = exp_dat[cur];
        end
      end else begin
        if (run != 0) begin
          n_checks++;
          if (run != S + T + 1) begin
            n_fail++;
            $display("FAIL cs_low_len op=%0d cyc=%0d got=%0d exp=%0d", op, cur, run, S + T + 1);
          end
          run = 0;
        end
        gap++;
        n_checks++;
        if (write_enable_n !== 1'b1 || read_enable_n !== 1'b1 || data_bus_oe !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_pins op=%0d k=%0d got_wr_n=%b rd_n=%b oe=%b exp=1,1,0", op, k, write_enable_n, read_enable_n, data_bus_oe);
        end
      end
      if (rsp_valid === 1'b1) begin
        done = 1'b1;
        n_checks++;
        if (k != exp_k || ncyc != exp_n) begin
          n_fail++;
          $display("FAIL rsp_timing op=%0d got_k=%0d got_cycles=%0d exp_k=%0d exp_cycles=%0d", op, k, ncyc, exp_k, exp_n);
        end
        n_checks++;
        if (rsp_data !== exp_rsp || rsp_error !== exp_err) begin
          n_fail++;
          $display("FAIL rsp_data op=%0d got=%h err=%b exp=%h err=%b", op, rsp_data, rsp_error, exp_rsp, exp_err);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL ready_at_rsp op=%0d got=%b exp=1", op, req_ready);
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout op=%0d waited=%0d", op, k);
    end else if (!b2b) begin
      @(negedge clock);
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== exp_rsp || chip_select_n !== 1'b1) begin
        n_fail++;
        $display("FAIL after_rsp op=%0d got_vld=%b data=%h cs_n=%b exp=0 %h 1", op, rsp_valid, rsp_data, chip_select_n, exp_rsp);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({chip_select_n, read_enable_n, write_enable_n, data_bus_oe, rsp_valid, rsp_error, req_ready} !== 7'b1110000 ||
        address !== 2'd0 || data_bus_out !== 8'h00 || rsp_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state got cs/rd/wr/oe/vld/err/rdy=%b%b%b%b%b%b%b addr=%0d dout=%h rsp=%h exp=1110000 0 00 0000",
               chip_select_n, read_enable_n, write_enable_n, data_bus_oe, rsp_valid, rsp_error, req_ready,
               address, data_bus_out, rsp_data);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1 || chip_select_n !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_release got rdy=%b cs_n=%b vld=%b exp=1 1 0", req_ready, chip_select_n, rsp_valid);
    end
  endtask

  task automatic test_write_byte();
    exec_cmd(2'b00, 2'd3, 2'b00, 16'h0036, 1'b0);
    for (int i = 0; i < 4; i++) exec_cmd(2'b00, 2'($urandom), 2'($urandom), 16'($urandom), 1'b0);
  endtask

  task automatic test_load_count();
    exec_cmd(2'b10, 2'd0, 2'b11, 16'h1234, 1'b0);
    exec_cmd(2'b10, 2'd1, 2'b01, 16'($urandom), 1'b0);
    exec_cmd(2'b10, 2'd2, 2'b10, 16'($urandom), 1'b0);
  endtask

  task automatic test_read_count();
    force_q.push_back(8'hCD);
    force_q.push_back(8'hAB);
    exec_cmd(2'b11, 2'd2, 2'b11, 16'($urandom), 1'b0);
    n_checks++;
    if (rsp_data !== 16'hABCD) begin
      n_fail++;
      $display("FAIL read_count_abcd got=%h exp=abcd", rsp_data);
    end
    force_q.push_back(8'h5A);
    exec_cmd(2'b11, 2'd1, 2'b10, 16'($urandom), 1'b0);
    n_checks++;
    if (rsp_data !== 16'h5A00) begin
      n_fail++;
      $display("FAIL read_count_msb got=%h exp=5a00", rsp_data);
    end
  endtask

  task automatic test_read_byte();
    for (int i = 0; i < 4; i++) exec_cmd(2'b01, 2'($urandom), 2'($urandom), 16'($urandom), 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) exec_cmd(2'($urandom), 2'($urandom), 2'($urandom), 16'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back();
    exec_cmd(2'b11, 2'd0, 2'b11, 16'h0000, 1'b1);
    exec_cmd(2'b00, 2'd2, 2'b00, 16'h00A5, 1'b1);
    exec_cmd(2'b01, 2'd1, 2'b00, 16'h0000, 1'b1);
    exec_cmd(2'b10, 2'd0, 2'b11, 16'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid_op();
    int w;
    req_valid = 1'b1; req_op = 2'b10; req_addr = 2'd0; req_rw_mode = 2'b11; req_data = 16'hBEEF;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (write_enable_n !== 1'b0 && w < 20);
    n_checks++;
    if (write_enable_n !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_op_no_strobe got=%b exp=0", write_enable_n);
    end
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if ({chip_select_n, write_enable_n, read_enable_n, data_bus_oe, rsp_valid, req_ready} !== 6'b111000) begin
      n_fail++;
      $display("FAIL mid_op_reset got cs/wr/rd/oe/vld/rdy=%b%b%b%b%b%b exp=111000",
               chip_select_n, write_enable_n, read_enable_n, data_bus_oe, rsp_valid, req_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      n_checks++;
      if (rsp_valid !== 1'b0 || chip_select_n !== 1'b1 || req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL post_abort i=%0d got vld=%b cs_n=%b rdy=%b exp=0 1 1", i, rsp_valid, chip_select_n, req_ready);
      end
    end
    exec_cmd(2'b10, 2'd1, 2'b11, 16'h4321, 1'b0);
  endtask

  task automatic test_mode00();
    exec_cmd(2'b10, 2'd2, 2'b00, 16'h9876, 1'b0);
    exec_cmd(2'b11, 2'd0, 2'b00, 16'h0000, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_rw_mode = '0; req_data = '0;
    data_bus_in = '0;
    @(negedge clock);
    test_reset();
    test_write_byte();
    test_load_count();
    test_read_count();
    test_read_byte();
    test_back_to_back();
    test_reset_mid_op();
    test_mode00();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
